// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Operand arrives sign- or zero-extended to 32 bits; the caller truncates.
    function automatic logic [31:0] abs_val(
        input logic [31:0] operand,
        input logic        is_signed
    );
        return (is_signed && operand[31]) ? (~operand + 32'd1) : operand;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, signed/unsigned, with valid/ready
// handshakes on request and response sides.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    localparam int WW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_e       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [WW-1:0]    r_y;
    logic             r_out_valid;

    logic [31:0]      w_a_ext;
    logic [31:0]      w_b_ext;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WW-1:0]    w_addend;
    logic [WW-1:0]    w_acc_nxt;

    assign w_a_ext = is_signed ? 32'(signed'(a)) : 32'(a);
    assign w_b_ext = is_signed ? 32'(signed'(b)) : 32'(b);
    // Magnitude of the most negative value fits as an unsigned WIDTH value.
    assign w_abs_a = WIDTH'(abs_val(w_a_ext, is_signed));
    assign w_abs_b = WIDTH'(abs_val(w_b_ext, is_signed));

    assign w_addend  = r_mplier[0] ? (WW'(r_mcand) << r_cnt) : '0;
    assign w_acc_nxt = r_acc + w_addend;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_y         <= r_neg ? (~w_acc_nxt + WW'(1)) : w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: WIDTH=4 corner cases plus a WIDTH=8
// sweep against a behavioural product.
module tb_mul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       iv4 = 1'b0, s4 = 1'b0, or4 = 1'b1;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ir4, ov4, busy4;
    logic [7:0] y4;

    logic       iv8 = 1'b0, s8 = 1'b0, or8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, busy8;
    logic [15:0] y8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .is_signed(s4),
        .out_valid(ov4), .out_ready(or4),
        .y(y4), .busy(busy4)
    );

    mul_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .is_signed(s8),
        .out_valid(ov8), .out_ready(or8),
        .y(y8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ov4(output int lat);
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] exp, input int hold, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(ir4), 32'd1);
        a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
        or4 = (hold == 0);
        @(posedge clk); #1;
        iv4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); s4 = ~s;
        wait_ov4(lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_y"}, 32'(y4), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_y"}, 32'(y4), 32'(exp));
            check({tag, "_hold_ov_rdy_busy"}, {29'd0, ov4, ir4, busy4}, 32'b101);
            @(posedge clk); #1;
        end
        or4 = 1'b1;
        @(posedge clk); #1;
        check({tag, "_post_ov_rdy_busy"}, {29'd0, ov4, ir4, busy4}, 32'b010);
        check({tag, "_post_y"}, 32'(y4), 32'(exp));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int lat, sa, sb;
        logic [15:0] exp;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        exp = 16'(sa * sb);
        @(negedge clk);
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_lat", 32'(lat), 32'd8);
        check("w8_y", 32'(y8), 32'(exp));
        @(posedge clk); #1;
        check("w8_idle", {30'd0, ov8, ir8}, 32'b01);
    endtask

    initial begin
        int lat;
        #1;
        check("rst_ov_y_busy_rdy4", {ov4, y4, busy4, ir4}, {1'b0, 8'h00, 1'b0, 1'b1});
        check("rst_ov_y_busy_rdy8", {ov8, y8, busy8, ir8}, {1'b0, 16'h0000, 1'b0, 1'b1});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op4(4'd15, 4'd15, 1'b0, 8'hE1, 0, "u15x15");
        op4(4'h8, 4'h8, 1'b1, 8'h40, 0, "s_m8xm8");
        op4(4'h8, 4'h7, 1'b1, 8'hC8, 0, "s_m8x7");
        op4(4'hF, 4'h1, 1'b1, 8'hFF, 0, "s_m1x1");
        op4(4'h0, 4'hB, 1'b1, 8'h00, 0, "s_0xm5");
        op4(4'hF, 4'h1, 1'b0, 8'h0F, 0, "u15x1");
        op4(4'd3, 4'd5, 1'b0, 8'h0F, 6, "bp3x5");

        // Second request held during the first operation must wait for IDLE.
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; s4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'd6; b4 = 4'd7;
        wait_ov4(lat);
        check("rej_lat1", 32'(lat), 32'd4);
        check("rej_y1", 32'(y4), 32'h0F);
        @(posedge clk); #1;
        check("rej_idle", {30'd0, ir4, busy4}, 32'b10);
        @(posedge clk); #1;
        iv4 = 1'b0;
        check("rej_accept2", {30'd0, ir4, busy4}, 32'b01);
        wait_ov4(lat);
        check("rej_lat2", 32'(lat), 32'd4);
        check("rej_y2", 32'(y4), 32'h2A);
        @(posedge clk); #1;

        // Reset two cycles into CALC discards the operation.
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd9; s4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid", {ov4, y4, busy4, ir4}, {1'b0, 8'h00, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        op4(4'd2, 4'd3, 1'b0, 8'h06, 0, "post_rst2x3");

        op8(8'h80, 8'h80, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'h80, 8'h7F, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 120; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
